// File: rtl/mnist_rx_assembler.sv
// mnist_rx_assembler
//
// Reassembles the per-bit UART bytes (0x00/0x01) coming back from the MNIST
// loop-back path into MSB-first pixel bytes. Each completed byte is written to
// an image RAM, and image boundaries are tracked. Bad byte values and
// mid-image inter-bit gaps are flagged as sticky errors.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse, (re)arms reception and clears all state
//   uart_rx_done  one-cycle strobe qualifying uart_rx_data
//   uart_rx_data  received byte, expected 0x00 or 0x01
//   ram_we        one-cycle RAM write strobe
//   ram_addr      RAM byte address
//   ram_wdata     assembled pixel byte
//   image_done    one-cycle pulse, aligned with the write of an image's last byte
//   image_cnt     images completed since start
//   last_ones     number of '1' bits in the most recently completed image
//   rx_active     high while receiving
//   rx_complete   high once the whole transfer has been written
//   err_bad       sticky: a byte other than 0x00/0x01 was received
//   err_gap       sticky: a mid-image gap timeout discarded a partial image

module mnist_rx_assembler #(
    parameter int unsigned BYTES_TOTAL     = 98000,
    parameter int unsigned BITS_PER_IMAGE  = 784,
    parameter int unsigned GAP_TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        uart_rx_done,
    input  logic [7:0]  uart_rx_data,
    output logic        ram_we,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        image_done,
    output logic [9:0]  image_cnt,
    output logic [9:0]  last_ones,
    output logic        rx_active,
    output logic        rx_complete,
    output logic        err_bad,
    output logic        err_gap
);

    localparam int unsigned BitW = (BITS_PER_IMAGE > 1) ? $clog2(BITS_PER_IMAGE) : 1;
    localparam int unsigned GapW = (GAP_TIMEOUT_CYC > 1) ? $clog2(GAP_TIMEOUT_CYC) : 1;

    localparam logic [BitW-1:0] LastBit  = BitW'(BITS_PER_IMAGE - 1);
    localparam logic [16:0]     LastByte = 17'(BYTES_TOTAL - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

    state_e state_q, state_d;

    logic [6:0]      shift_q, shift_d;
    logic [2:0]      bit_pos_q, bit_pos_d;
    logic [BitW-1:0] bit_in_img_q, bit_in_img_d;
    logic [16:0]     byte_idx_q, byte_idx_d;
    logic [16:0]     img_base_q, img_base_d;
    logic [9:0]      ones_q, ones_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [9:0]      image_cnt_q, image_cnt_d;
    logic [9:0]      last_ones_q, last_ones_d;
    logic            err_bad_q, err_bad_d;
    logic            err_gap_q, err_gap_d;
    logic            ram_we_q, ram_we_d;
    logic [16:0]     ram_addr_q, ram_addr_d;
    logic [7:0]      ram_wdata_q, ram_wdata_d;
    logic            image_done_q, image_done_d;

    logic       recv;
    logic       bit_valid;
    logic       mid_image;
    logic [7:0] new_byte;
    logic [9:0] bit_ext;
    logic       xfer_end;

    assign recv      = (state_q == StRecv);
    assign bit_valid = uart_rx_done && (uart_rx_data[7:1] == 7'd0);
    // Between images (both positions zero) idling is legal, so no gap counting.
    assign mid_image = (bit_pos_q != 3'd0) || (bit_in_img_q != '0);
    assign new_byte  = {shift_q, uart_rx_data[0]};
    assign bit_ext   = {9'd0, uart_rx_data[0]};
    assign xfer_end  = recv && bit_valid && (bit_pos_q == 3'd7) && (byte_idx_q == LastByte);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start wins over everything, including a concurrent strobe
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StRecv;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StRecv:  if (xfer_end) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        rx_active   = (state_q == StRecv);
        rx_complete = (state_q == StDone);
    end

    // Datapath next state
    always_comb begin
        shift_d      = shift_q;
        bit_pos_d    = bit_pos_q;
        bit_in_img_d = bit_in_img_q;
        byte_idx_d   = byte_idx_q;
        img_base_d   = img_base_q;
        ones_d       = ones_q;
        gap_cnt_d    = gap_cnt_q;
        image_cnt_d  = image_cnt_q;
        last_ones_d  = last_ones_q;
        err_bad_d    = err_bad_q;
        err_gap_d    = err_gap_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        image_done_d = 1'b0;

        if (start) begin
            shift_d      = '0;
            bit_pos_d    = '0;
            bit_in_img_d = '0;
            byte_idx_d   = '0;
            img_base_d   = '0;
            ones_d       = '0;
            gap_cnt_d    = '0;
            image_cnt_d  = '0;
            last_ones_d  = '0;
            err_bad_d    = 1'b0;
            err_gap_d    = 1'b0;
        end else if (recv) begin
            if (uart_rx_done) begin
                // A bad byte is still a strobe: it holds the gap counter.
                if (!bit_valid) begin
                    err_bad_d = 1'b1;
                end else begin
                    shift_d      = new_byte[6:0];
                    bit_pos_d    = bit_pos_q + 3'd1;
                    bit_in_img_d = bit_in_img_q + 1'b1;
                    ones_d       = ones_q + bit_ext;
                    gap_cnt_d    = '0;
                    if (bit_pos_q == 3'd7) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = byte_idx_q;
                        ram_wdata_d = new_byte;
                        byte_idx_d  = byte_idx_q + 17'd1;
                        bit_pos_d   = 3'd0;
                    end
                    if (bit_in_img_q == LastBit) begin
                        image_done_d = 1'b1;
                        image_cnt_d  = image_cnt_q + 10'd1;
                        last_ones_d  = ones_q + bit_ext;
                        ones_d       = '0;
                        bit_in_img_d = '0;
                        img_base_d   = byte_idx_q + 17'd1;
                    end
                end
            end else if (mid_image) begin
                if (gap_cnt_q == GapLast) begin
                    // Drop the partial image and rewrite it from its first byte.
                    err_gap_d    = 1'b1;
                    bit_pos_d    = '0;
                    bit_in_img_d = '0;
                    ones_d       = '0;
                    gap_cnt_d    = '0;
                    byte_idx_d   = img_base_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            bit_pos_q    <= '0;
            bit_in_img_q <= '0;
            byte_idx_q   <= '0;
            img_base_q   <= '0;
            ones_q       <= '0;
            gap_cnt_q    <= '0;
            image_cnt_q  <= '0;
            last_ones_q  <= '0;
            err_bad_q    <= 1'b0;
            err_gap_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            image_done_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_pos_q    <= bit_pos_d;
            bit_in_img_q <= bit_in_img_d;
            byte_idx_q   <= byte_idx_d;
            img_base_q   <= img_base_d;
            ones_q       <= ones_d;
            gap_cnt_q    <= gap_cnt_d;
            image_cnt_q  <= image_cnt_d;
            last_ones_q  <= last_ones_d;
            err_bad_q    <= err_bad_d;
            err_gap_q    <= err_gap_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            image_done_q <= image_done_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign image_done = image_done_q;
    assign image_cnt  = image_cnt_q;
    assign last_ones  = last_ones_q;
    assign err_bad    = err_bad_q;
    assign err_gap    = err_gap_q;

endmodule

// File: tb/tb_mnist_rx_assembler.sv
// tb_mnist_rx_assembler
//
// Drives directed and randomized per-bit byte streams into mnist_rx_assembler
// and checks every cycle against a queue-based model of the current image,
// plus literal expectations for the hand-worked cases.

module tb_mnist_rx_assembler;

    localparam int BT  = 196;
    localparam int BPI = 784;
    localparam int GAP = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        uart_rx_done = 1'b0;
    logic [7:0]  uart_rx_data = 8'd0;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        image_done;
    logic [9:0]  image_cnt;
    logic [9:0]  last_ones;
    logic        rx_active;
    logic        rx_complete;
    logic        err_bad;
    logic        err_gap;

    mnist_rx_assembler #(
        .BYTES_TOTAL     (BT),
        .BITS_PER_IMAGE  (BPI),
        .GAP_TIMEOUT_CYC (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .image_done   (image_done),
        .image_cnt    (image_cnt),
        .last_ones    (last_ones),
        .rx_active    (rx_active),
        .rx_complete  (rx_complete),
        .err_bad      (err_bad),
        .err_gap      (err_gap)
    );

    always #25 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    // mode: 0 idle, 1 receiving, 2 transfer complete
    int mode = 0;
    int bits[$];
    int img_base = 0;
    int m_img_cnt = 0;
    int m_last_ones = 0;
    int m_err_bad = 0;
    int m_err_gap = 0;
    int idle_run = 0;
    int exp_we = 0;
    int exp_addr = 0;
    int exp_wdata = 0;
    int exp_done = 0;

    task automatic model_reset();
        mode = 0;
        bits.delete();
        img_base = 0;
        m_img_cnt = 0;
        m_last_ones = 0;
        m_err_bad = 0;
        m_err_gap = 0;
        idle_run = 0;
        exp_we = 0;
        exp_done = 0;
    endtask

    task automatic model_step();
        exp_we = 0;
        exp_done = 0;
        if (start) begin
            mode = 1;
            bits.delete();
            img_base = 0;
            m_img_cnt = 0;
            m_last_ones = 0;
            m_err_bad = 0;
            m_err_gap = 0;
            idle_run = 0;
        end else if (mode == 1) begin
            if (uart_rx_done) begin
                if (uart_rx_data > 8'd1) begin
                    m_err_bad = 1;
                end else begin
                    bits.push_back(int'(uart_rx_data[0]));
                    idle_run = 0;
                    if (bits.size() % 8 == 0) begin
                        int v = 0;
                        for (int k = bits.size() - 8; k < bits.size(); k++) v = v * 2 + bits[k];
                        exp_we = 1;
                        exp_addr = img_base + bits.size() / 8 - 1;
                        exp_wdata = v;
                    end
                    if (bits.size() == BPI) begin
                        int s = 0;
                        foreach (bits[k]) s += bits[k];
                        exp_done = 1;
                        m_img_cnt = (m_img_cnt + 1) % 1024;
                        m_last_ones = s;
                        img_base += BPI / 8;
                        bits.delete();
                    end
                    if (exp_we == 1 && exp_addr == BT - 1) mode = 2;
                end
            end else if (bits.size() != 0) begin
                // GAP consecutive strobe-free cycles mid-image drop the partial image
                if (idle_run == GAP - 1) begin
                    m_err_gap = 1;
                    bits.delete();
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- Per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ram_we", int'(ram_we), exp_we);
                chk("image_done", int'(image_done), exp_done);
                chk("image_cnt", int'(image_cnt), m_img_cnt);
                chk("last_ones", int'(last_ones), m_last_ones);
                chk("err_bad", int'(err_bad), m_err_bad);
                chk("err_gap", int'(err_gap), m_err_gap);
                chk("rx_active", int'(rx_active), int'(mode == 1));
                chk("rx_complete", int'(rx_complete), int'(mode == 2));
                if (exp_we == 1) begin
                    chk("ram_addr", int'(ram_addr), exp_addr);
                    chk("ram_wdata", int'(ram_wdata), exp_wdata);
                end
            end
        end
    end

    // ---------------- Write / image log ----------------
    int wa[$];
    int wd[$];
    int dl[$];
    int dc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (ram_we) begin
                wa.push_back(int'(ram_addr));
                wd.push_back(int'(ram_wdata));
            end
            if (image_done) begin
                dl.push_back(int'(last_ones));
                dc.push_back(int'(image_cnt));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic cycle(input logic s, input logic d, input logic [7:0] v);
        @(negedge clk);
        start = s;
        uart_rx_done = d;
        uart_rx_data = v;
    endtask

    task automatic send(input logic [7:0] v);
        cycle(1'b0, 1'b1, v);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic pulse_start();
        cycle(1'b1, 1'b0, 8'd0);
    endtask

    task automatic send_rand(input int n);
        repeat (n) send(8'($urandom_range(0, 1)));
    endtask

    task automatic settle();
        idle(3);
        #1;
    endtask

    initial begin
        int base;
        int dbase;
        int nbad;
        logic [7:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_image_cnt", int'(image_cnt), 0);
        chk("rst_rx_active", int'(rx_active), 0);
        chk("rst_err_bad", int'(err_bad), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Strobes while idle are ignored
        base = wa.size();
        send_rand(16);
        settle();
        chk("idle_no_write", wa.size() - base, 0);

        // Single byte 1,0,1,1,0,0,1,0 -> 0xB2 at address 0
        base = wa.size();
        dbase = dl.size();
        pulse_start();
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            send({7'd0, pat[i]});
            idle($urandom_range(0, 2));
        end
        settle();
        chk("b2_nwrites", wa.size() - base, 1);
        chk("b2_addr", (wa.size() > base) ? wa[base] : -1, 0);
        chk("b2_data", (wd.size() > base) ? wd[base] : -1, 8'hB2);
        chk("b2_no_image_done", dl.size() - dbase, 0);

        // Full image of ones, back to back
        pulse_start();
        base = wa.size();
        dbase = dl.size();
        repeat (BPI) send(8'h01);
        settle();
        chk("ones_nwrites", wa.size() - base, 98);
        nbad = 0;
        for (int i = 0; i < 98; i++) begin
            if (wa.size() > base + i) begin
                if (wd[base + i] != 8'hFF || wa[base + i] != i) nbad++;
            end
        end
        chk("ones_bytes_ff", nbad, 0);
        chk("ones_ndone", dl.size() - dbase, 1);
        chk("ones_last_ones", (dl.size() > dbase) ? dl[dbase] : -1, 784);
        chk("ones_image_cnt", (dc.size() > dbase) ? dc[dbase] : -1, 1);

        // Bad byte in the middle of a byte: discarded, byte formed from valid bits
        pulse_start();
        base = wa.size();
        send(8'h01); send(8'h01); send(8'h00);
        send(8'h41);
        send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h01);
        settle();
        chk("bad_err_bad", int'(err_bad), 1);
        chk("bad_nwrites", wa.size() - base, 1);
        chk("bad_data", (wd.size() > base) ? wd[base] : -1, 8'hD5);

        // Gap timeout in image 1, then rewrite and complete the transfer
        pulse_start();
        base = wa.size();
        send_rand(BPI);
        send_rand(300);
        idle(GAP + 16);
        #1;
        chk("gap_err_gap", int'(err_gap), 1);
        send_rand(BPI);
        settle();
        chk("gap_nwrites", wa.size() - base, 233);
        chk("gap_rewrite_first", (wa.size() > base + 135) ? wa[base + 135] : -1, 98);
        chk("gap_rewrite_last", (wa.size() > base + 232) ? wa[base + 232] : -1, 195);
        chk("gap_image_cnt", int'(image_cnt), 2);
        chk("done_rx_complete", int'(rx_complete), 1);
        chk("done_rx_active", int'(rx_active), 0);
        base = wa.size();
        send_rand(10);
        settle();
        chk("done_no_write", wa.size() - base, 0);
        pulse_start();
        send_rand(8);
        settle();
        chk("restart_addr", (wa.size() > base) ? wa[base] : -1, 0);

        // Gap boundary: strobe on the last counted cycle wins, one more idle fires
        pulse_start();
        send(8'h01);
        idle(GAP - 1);
        send(8'h00);
        #1;
        idle(GAP);
        #1;
        chk("gap_edge_not_yet", int'(err_gap), 0);
        idle(1);
        #1;
        chk("gap_edge_fired", int'(err_gap), 1);

        // Start mid-image restarts at address 0
        pulse_start();
        send_rand(20);
        pulse_start();
        base = wa.size();
        send_rand(8);
        settle();
        chk("mid_start_addr", (wa.size() > base) ? wa[base] : -1, 0);

        // Start and strobe together: strobe dropped
        send_rand(3);
        base = wa.size();
        cycle(1'b1, 1'b1, 8'h01);
        pat = 8'h55;
        for (int i = 7; i >= 0; i--) send({7'd0, pat[i]});
        settle();
        chk("start_strobe_data", (wd.size() > base) ? wd[base] : -1, 8'h55);

        // Async reset mid-image
        pulse_start();
        send_rand(100);
        @(negedge clk);
        uart_rx_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ram_addr", int'(ram_addr), 0);
        chk("arst_ram_wdata", int'(ram_wdata), 0);
        chk("arst_rx_active", int'(rx_active), 0);
        chk("arst_last_ones", int'(last_ones), 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = wa.size();
        send_rand(16);
        settle();
        chk("arst_no_resume", wa.size() - base, 0);

        // Randomized traffic
        pulse_start();
        for (int it = 0; it < 6000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (rx_complete) pulse_start();
            else if (r < 3) send(8'($urandom_range(2, 255)));
            else if (r < 5) idle($urandom_range(GAP - 4, GAP + 4));
            else if (r < 6) pulse_start();
            else if (r < 8) cycle(1'b1, 1'b1, 8'($urandom_range(0, 1)));
            else begin
                send(8'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
            end
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
